ps2_device_tx: RTL and testbench

- PS/2 device-side transmitter: serializes queued scan-code bytes onto ps2_clk/ps2_data as standard 11-bit device-to-host frames.
- Provides the keyboard end of the link that ps2_keyboard receives, for loopback self-test, for simulation stimulus, and for injecting key sequences from sw/btn or UART.
- Sits beside ps2_keyboard in top; its outputs drive that receiver's ps2_clk/ps2_data inputs in loopback builds.

---
 rtl/ps2_pkg.sv | 20 ++
 rtl/ps2_device_tx_byte_fifo.sv | 53 +++++
 rtl/ps2_device_tx.sv | 145 ++++++++++++++
 tb/tb_ps2_device_tx.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter FSM states, frame layout constants and parity helper.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BIT_HI = 2'd1,
    BIT_LO = 2'd2,
    GAP    = 2'd3
  } ps2_state_e;

  localparam int   PS2_FRAME_BITS = 11;
  localparam logic PS2_START      = 1'b0;
  localparam logic PS2_STOP       = 1'b1;

  // Odd parity: the bit that makes the total count of ones across data+parity odd.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_device_tx_byte_fifo.sv
// Small synchronous byte queue with wrap-bit pointers; simultaneous push and pop allowed even when full.
module byte_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_wr;
  logic             do_rd;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  // When full, a write is only legal if the head leaves in the same cycle.
  assign do_wr = wr_en && (!full || rd_en);
  assign do_rd = rd_en && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/ps2_device_tx.sv
// PS/2 device-side transmitter: drains a byte queue as 11-bit device-to-host frames on ps2_clk/ps2_data.
module ps2_device_tx
  import ps2_pkg::*;
#(
  parameter int HALF_PERIOD = 8,
  parameter int GAP_CYCLES  = 32,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       inhibit,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       busy,
  output logic [7:0] frames_sent
);

  localparam int DIV_W = $clog2(HALF_PERIOD);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [3:0] LAST_BIT = 4'(PS2_FRAME_BITS - 1);

  ps2_state_e                state_q, state_d;
  logic [DIV_W-1:0]          div_q, div_d;
  logic [GAP_W-1:0]          gap_q, gap_d;
  logic [3:0]                bit_q, bit_d;
  logic [PS2_FRAME_BITS-1:0] frame_q, frame_d;
  logic [7:0]                frames_q, frames_d;

  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] fifo_head;
  logic       fifo_pop;
  logic       div_last;
  logic       gap_last;

  byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (in_valid && in_ready),
    .wr_data (in_data),
    .rd_en   (fifo_pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign div_last = (div_q == DIV_W'(HALF_PERIOD - 1));
  assign gap_last = (gap_q == GAP_W'(GAP_CYCLES - 1));

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    gap_d    = gap_q;
    bit_d    = bit_q;
    frame_d  = frame_q;
    frames_d = frames_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty && !inhibit) begin
          state_d = BIT_HI;
          bit_d   = 4'd0;
          div_d   = '0;
          frame_d = {PS2_STOP, odd_parity(fifo_head), fifo_head, PS2_START};
        end
      end
      BIT_HI: begin
        if (inhibit) begin
          state_d = GAP;
          gap_d   = '0;
          div_d   = '0;
        end else if (div_last) begin
          state_d = BIT_LO;
          div_d   = '0;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      BIT_LO: begin
        if (inhibit) begin
          state_d = GAP;
          gap_d   = '0;
          div_d   = '0;
        end else if (div_last) begin
          div_d = '0;
          // The head byte leaves the queue only once its stop bit has been clocked out.
          if (bit_q == LAST_BIT) begin
            fifo_pop = 1'b1;
            frames_d = frames_q + 8'd1;
            state_d  = GAP;
            gap_d    = '0;
          end else begin
            bit_d   = bit_q + 4'd1;
            state_d = BIT_HI;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      GAP: begin
        if (gap_last) begin
          state_d = IDLE;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      div_q    <= '0;
      gap_q    <= '0;
      bit_q    <= 4'd0;
      frames_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      gap_q    <= gap_d;
      bit_q    <= bit_d;
      frames_q <= frames_d;
    end
  end

  always_ff @(posedge clk) begin
    frame_q <= frame_d;
  end

  // Line outputs decode straight from state so an async reset idles them at once.
  assign ps2_clk     = (state_q != BIT_LO);
  assign ps2_data    = ((state_q == BIT_HI) || (state_q == BIT_LO)) ? frame_q[bit_q] : 1'b1;
  assign busy        = (state_q != IDLE);
  assign in_ready    = !fifo_full;
  assign frames_sent = frames_q;

endmodule

// File: tb/tb_ps2_device_tx.sv
// Directed bench for ps2_device_tx: a line monitor captures frames at ps2_clk falling edges.
module tb_ps2_device_tx;

  localparam int HP = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       inhibit;
  logic       ps2_clk;
  logic       ps2_data;
  logic       busy;
  logic [7:0] frames_sent;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  ps2_device_tx #(
    .HALF_PERIOD (HP),
    .GAP_CYCLES  (32),
    .FIFO_DEPTH  (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .inhibit     (inhibit),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .busy        (busy),
    .frames_sent (frames_sent)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Line monitor: sample away from the clock edge, record ps2_data on each ps2_clk fall.
  logic [10:0] cap_q[$];
  logic [10:0] mon_sh;
  int          mon_nbits = 0;
  int          mon_hi    = 0;
  logic        mon_prev  = 1'b1;

  always @(negedge clk) begin
    if (rst) begin
      mon_nbits = 0;
      mon_hi    = 0;
    end else begin
      if (mon_prev && !ps2_clk) begin
        mon_sh[mon_nbits] = ps2_data;
        mon_nbits++;
        if (mon_nbits == 11) begin
          cap_q.push_back(mon_sh);
          mon_nbits = 0;
        end
      end
      if (ps2_clk) mon_hi++;
      else mon_hi = 0;
      if (mon_hi > 2*HP) mon_nbits = 0;
    end
    mon_prev = ps2_clk;
  end

  function automatic logic [10:0] frame_of(input logic [7:0] b);
    logic p;
    p = 1'b1;
    for (int i = 0; i < 8; i++) if (b[i]) p = ~p;
    return {1'b1, p, b, 1'b0};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_caps(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (cap_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(cap_q.size() >= n), 32'd1);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int k;
    k = 0;
    while (busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  initial begin
    int   c0, n, acc, base;
    logic rdy, prev_rdy, seen8, seenpop;
    logic [10:0] exp_par [4];

    rst      = 1'b1;
    in_data  = 8'h00;
    in_valid = 1'b0;
    inhibit  = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ps2_clk", 32'(ps2_clk), 32'd1);
    check("rst_ps2_data", 32'(ps2_data), 32'd1);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frames", 32'(frames_sent), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single byte 0x1C: latency, bit pattern, frame length, gap length.
    cap_q.delete();
    in_data  = 8'h1C;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("lat1_data", 32'(ps2_data), 32'd1);
    @(negedge clk);
    check("lat2_data", 32'(ps2_data), 32'd0);
    check("lat2_busy", 32'(busy), 32'd1);
    c0 = cyc;
    n = 0;
    while (frames_sent == 8'd0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("frame_len", 32'(cyc - c0), 32'd88);
    check("frames_1", 32'(frames_sent), 32'd1);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("gap_len", 32'(n), 32'd32);
    wait_caps(1, 10, "cap_1c");
    if (cap_q.size() > 0) check("frame_1c", 32'(cap_q.pop_front()), 32'h438);

    // Parity corner bytes.
    cap_q.delete();
    push_byte(8'hF0);
    push_byte(8'h00);
    push_byte(8'hFF);
    push_byte(8'h01);
    exp_par = '{11'h7E0, 11'h600, 11'h7FE, 11'h402};
    wait_caps(4, 1000, "cap_parity");
    for (int i = 0; i < 4; i++)
      if (cap_q.size() > 0) check($sformatf("parity_%0d", i), 32'(cap_q.pop_front()), 32'(exp_par[i]));
    wait_idle(100, "idle_parity");
    check("frames_5", 32'(frames_sent), 32'd5);

    // Full queue with in_valid held high.
    cap_q.delete();
    base     = int'(frames_sent);
    acc      = 0;
    seen8    = 1'b0;
    seenpop  = 1'b0;
    prev_rdy = 1'b1;
    for (int k = 0; k < 3000 && acc < 10; k++) begin
      @(negedge clk);
      if (acc == 8 && !seen8) begin
        check("full_ready_low", 32'(in_ready), 32'd0);
        seen8 = 1'b1;
      end
      if (!seenpop && int'(frames_sent) != base) begin
        check("ready_after_pop", 32'(in_ready), 32'd1);
        check("ready_before_pop", 32'(prev_rdy), 32'd0);
        seenpop = 1'b1;
      end
      prev_rdy = in_ready;
      in_data  = 8'(acc + 1);
      in_valid = 1'b1;
      rdy      = in_ready;
      @(posedge clk);
      if (rdy) acc++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("full_accepted", 32'(acc), 32'd10);
    wait_caps(10, 2000, "cap_full");
    for (int i = 0; i < 10; i++)
      if (cap_q.size() > 0) check($sformatf("full_byte_%0d", i + 1), 32'(cap_q.pop_front()), 32'(frame_of(8'(i + 1))));
    wait_idle(100, "idle_full");
    check("frames_15", 32'(frames_sent), 32'd15);

    // Inhibit during bit 4 of 0x5A, then retransmit.
    cap_q.delete();
    push_byte(8'h5A);
    n = 0;
    while (!(mon_nbits == 4 && ps2_clk) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("inh_reach_bit4", 32'(mon_nbits == 4 && ps2_clk), 32'd1);
    inhibit = 1'b1;
    @(negedge clk);
    check("inh_clk", 32'(ps2_clk), 32'd1);
    check("inh_data", 32'(ps2_data), 32'd1);
    check("inh_frames", 32'(frames_sent), 32'd15);
    repeat (49) @(negedge clk);
    check("inh_idle", 32'(busy), 32'd0);
    check("inh_frames_hold", 32'(frames_sent), 32'd15);
    inhibit = 1'b0;
    wait_caps(1, 400, "cap_retx");
    if (cap_q.size() > 0) check("retx_5a", 32'(cap_q.pop_front()), 32'h6B4);
    wait_idle(100, "idle_retx");
    check("frames_16", 32'(frames_sent), 32'd16);
    check("retx_single", 32'(cap_q.size()), 32'd0);

    // Async reset during bit 6 of 0x33 with two more bytes queued.
    cap_q.delete();
    push_byte(8'h33);
    push_byte(8'h44);
    push_byte(8'h55);
    n = 0;
    while (!(mon_nbits == 6 && ps2_clk) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rst_reach_bit6", 32'(mon_nbits == 6 && ps2_clk), 32'd1);
    rst = 1'b1;
    #1;
    check("midrst_clk", 32'(ps2_clk), 32'd1);
    check("midrst_data", 32'(ps2_data), 32'd1);
    check("midrst_ready", 32'(in_ready), 32'd1);
    check("midrst_frames", 32'(frames_sent), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (300) @(negedge clk);
    check("postrst_nocap", 32'(cap_q.size()), 32'd0);
    check("postrst_frames", 32'(frames_sent), 32'd0);
    check("postrst_busy", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
